// File: rtl/byte_fifo_reader_pkg.sv
// byte_fifo_reader_pkg -- shared defaults for the byte FIFO (rev 1.0).
// Optional error flags are enabled by defining BYTE_FIFO_ERR_FLAGS_EN.
`default_nettype none

package byte_fifo_reader_pkg;

  localparam int DEFAULT_N          = 7;
  localparam int DEFAULT_DEPTH_LOG2 = 2;

  // Number of storage entries for a given pointer width.
  function automatic int fifo_depth(input int depth_log2);
    return 1 << depth_log2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_fifo_mem.sv
// byte_fifo_mem -- storage array with one write port and a registered read port (rev 1.0).
`default_nettype none

module byte_fifo_mem
  import byte_fifo_reader_pkg::*;
#(
  parameter int W  = DEFAULT_N + 1,
  parameter int AW = DEFAULT_DEPTH_LOG2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  localparam int DEPTH = fifo_depth(AW);

  logic [W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read-before-write: a same-address write lands after the old byte is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: rtl/byte_fifo_reader.sv
// byte_fifo_reader -- registered, handshaked byte FIFO with 1-cycle read latency (rev 1.0).
// Define BYTE_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
`default_nettype none

module byte_fifo_reader
  import byte_fifo_reader_pkg::*;
#(
  parameter int N          = DEFAULT_N,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [N:0]          wr_data,
  output logic                full,
  input  logic                rd_en,
  output logic [N:0]          rd_data,
  output logic                rd_valid,
  output logic                empty,
  output logic [DEPTH_LOG2:0] count
`ifdef BYTE_FIFO_ERR_FLAGS_EN
  ,
  output logic                overflow,
  output logic                underflow
`endif
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic                  rd_acc;
  logic                  wr_acc;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_next;

  // A write into a full FIFO is accepted only when a read frees a slot the same cycle.
  always_comb begin
    rd_acc     = rd_en & ~empty;
    wr_acc     = wr_en & (~full | rd_acc);
    count_next = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == FULL_CNT);
      rd_valid <= rd_acc;
    end
  end

`ifdef BYTE_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc) overflow  <= 1'b1;
      if (rd_en & empty)   underflow <= 1'b1;
    end
  end
`endif

  byte_fifo_mem #(
    .W  (N + 1),
    .AW (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_byte_fifo_reader.sv
// tb_byte_fifo_reader -- directed and random stimulus checked against a queue-based FIFO model.
`default_nettype none

module tb_byte_fifo_reader;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       full;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic [2:0] count;
`ifdef BYTE_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  byte_fifo_reader dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .count    (count)
`ifdef BYTE_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain queue plus the last byte handed out.
  logic [7:0] q[$];
  logic [7:0] exp_data  = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ovf   = 1'b0;
  logic       exp_udf   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"},    32'(count),    32'(q.size()));
    check_eq({tag, ".empty"},    32'(empty),    32'(q.size() == 0));
    check_eq({tag, ".full"},     32'(full),     32'(q.size() == DEPTH));
    check_eq({tag, ".rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    check_eq({tag, ".rd_data"},  32'(rd_data),  32'(exp_data));
`ifdef BYTE_FIFO_ERR_FLAGS_EN
    check_eq({tag, ".overflow"},  32'(overflow),  32'(exp_ovf));
    check_eq({tag, ".underflow"}, 32'(underflow), 32'(exp_udf));
`endif
  endtask

  // One clock cycle with the given request; inputs change 1 time unit after posedge.
  task automatic step(input string tag, input logic we, input logic [7:0] wd, input logic re);
    logic racc, wacc;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    racc = re && (q.size() > 0);
    wacc = we && ((q.size() < DEPTH) || racc);
    if (we && !wacc) exp_ovf = 1'b1;
    if (re && q.size() == 0) exp_udf = 1'b1;
    @(posedge clk);
    #1;
    if (racc) exp_data = q.pop_front();
    exp_valid = racc;
    if (wacc) q.push_back(wd);
    check_outputs(tag);
  endtask

  // Reset with every request asserted, to show reset has priority.
  task automatic do_reset(input string tag);
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_outputs(tag);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
    step({tag, "_idle"}, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] fill [4] = '{8'h00, 8'h0A, 8'hB0, 8'hC0};

    do_reset("reset");

    foreach (fill[i]) step("fill", 1'b1, fill[i], 1'b0);
    step("ovf_drop", 1'b1, 8'h49, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1);
    check_eq("drain_last", 32'(rd_data), 32'(8'hC0));

    foreach (fill[i]) step("refill", 1'b1, fill[i] ^ 8'h11, 1'b0);
    step("full_rw", 1'b1, 8'h46, 1'b1);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 8'h00, 1'b1);
    check_eq("full_rw_last", 32'(rd_data), 32'(8'h46));

    step("empty_rw", 1'b1, 8'h24, 1'b1);
    step("empty_rd1", 1'b0, 8'h00, 1'b1);
    check_eq("empty_rd1_data", 32'(rd_data), 32'(8'h24));
    step("empty_rd2", 1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 9; i++) begin
      step("wrap_wr", 1'b1, 8'(i * 9), 1'b0);
      if (i % 2 == 1) step("wrap_rd", 1'b0, 8'h00, 1'b1);
    end
    while (q.size() > 0) step("wrap_drain", 1'b0, 8'h00, 1'b1);
    check_eq("wrap_last", 32'(rd_data), 32'(8'h48));

    step("mid_wr0", 1'b1, 8'h5A, 1'b0);
    step("mid_wr1", 1'b1, 8'hA5, 1'b0);
    step("mid_wr2", 1'b1, 8'h3C, 1'b1);
    do_reset("mid_reset");

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    do_reset("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
